// File: rtl/la_logic_pkg.sv
// Shared definitions for the la_* bitwise logic pipelines.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package la_logic_pkg;

    typedef enum logic [1:0] {
        OAI311 = 2'b00,
        OA311  = 2'b01,
        AOI311 = 2'b10,
        AO311  = 2'b11
    } la_mode_e;

    localparam int LA_MAX_W     = 64;
    localparam int LA_MAX_DEPTH = 8;

endpackage

// File: rtl/la_pipe_stage.sv
// One pipeline slot: W-bit payload plus valid flag.
// Latency: 1 cycle from load to visible output.
// Backpressure: parent asserts ld only when this slot is empty or draining.
module la_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic         up_vld,
    input  logic [W-1:0] up_dat,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (ld) begin
            vld <= up_vld;
            // Payload only moves with a real transfer; bubbles leave it untouched.
            if (up_vld) begin
                dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/la_oai311_pipe.sv
// Mode-selectable OAI311/OA311/AOI311/AO311 function with a DEPTH-slot valid/ready pipeline.
// Latency: DEPTH cycles from accept to out_valid when out_ready stays high.
// Backpressure: bubbles collapse; in_ready falls only when every slot is full and out_ready is low.
module la_oai311_pipe
    import la_logic_pkg::*;
#(
    parameter string PROP  = "DEFAULT",
    parameter int    W     = 1,
    parameter int    DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] c0,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    if (W < 1 || W > LA_MAX_W || DEPTH < 1 || DEPTH > LA_MAX_DEPTH || PROP == "") begin : g_param_chk
        $error("la_oai311_pipe: W must be 1..64, DEPTH 1..8, PROP non-empty");
    end

    logic [W-1:0] or3;
    logic [W-1:0] and3;
    logic [W-1:0] fn_dat;

    assign or3  = a0 | a1 | a2;
    assign and3 = a0 & a1 & a2;

    always_comb begin
        fn_dat = '0;
        case (la_mode_e'(mode))
            OAI311:  fn_dat = ~(or3 & b0 & c0);
            OA311:   fn_dat = or3 & b0 & c0;
            AOI311:  fn_dat = ~(and3 | b0 | c0);
            AO311:   fn_dat = and3 | b0 | c0;
            default: fn_dat = '0;
        endcase
    end

    logic [DEPTH:0]   stg_rdy;
    logic [DEPTH-1:0] stg_vld;
    logic [W-1:0]     stg_dat [DEPTH];

    // Ready ripples back from the consumer: a slot can load if empty or its occupant moves on.
    always_comb begin
        stg_rdy        = '0;
        stg_rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stg_rdy[k] = ~stg_vld[k] | stg_rdy[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic         up_vld;
        logic [W-1:0] up_dat;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_dat = fn_dat;
        end else begin : g_body
            assign up_vld = stg_vld[k-1];
            assign up_dat = stg_dat[k-1];
        end

        la_pipe_stage #(
            .W(W)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .ld    (stg_rdy[k]),
            .up_vld(up_vld),
            .up_dat(up_dat),
            .vld   (stg_vld[k]),
            .dat   (stg_dat[k])
        );
    end

    assign in_ready  = stg_rdy[0];
    assign out_valid = stg_vld[DEPTH-1];
    assign z         = stg_dat[DEPTH-1];
    assign busy      = |stg_vld;

endmodule

// File: tb/tb_la_oai311_pipe.sv
// Directed and randomised checks of la_oai311_pipe at W=4/DEPTH=2 and W=64/DEPTH=1,8.
module tb_la_oai311_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] a0, a1, a2, b0, c0, z;
    logic [1:0] mode;
    logic       in_valid, in_ready, out_valid, out_ready, busy;

    logic [63:0] ra0, ra1, ra2, rb0, rc0;
    logic [1:0]  rmode;
    logic        r_in_valid, r_out_ready;
    logic        d1_in_ready, d1_out_valid, d1_busy;
    logic        d8_in_ready, d8_out_valid, d8_busy;
    logic [63:0] d1_z, d8_z;

    int n_cmp = 0;
    int n_err = 0;

    la_oai311_pipe #(.PROP("DEFAULT"), .W(4), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .a0(a0), .a1(a1), .a2(a2), .b0(b0), .c0(c0),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .z(z),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    la_oai311_pipe #(.PROP("DEFAULT"), .W(64), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .a0(ra0), .a1(ra1), .a2(ra2), .b0(rb0), .c0(rc0),
        .mode(rmode), .in_valid(r_in_valid), .in_ready(d1_in_ready), .z(d1_z),
        .out_valid(d1_out_valid), .out_ready(r_out_ready), .busy(d1_busy)
    );

    la_oai311_pipe #(.PROP("DEFAULT"), .W(64), .DEPTH(8)) u_d8 (
        .clk(clk), .reset(reset), .a0(ra0), .a1(ra1), .a2(ra2), .b0(rb0), .c0(rc0),
        .mode(rmode), .in_valid(r_in_valid), .in_ready(d8_in_ready), .z(d8_z),
        .out_valid(d8_out_valid), .out_ready(r_out_ready), .busy(d8_busy)
    );

    function automatic logic [63:0] ref_fn(input logic [1:0] m, input logic [63:0] x0, x1, x2, y, w);
        case (m)
            2'b00:   return ~((x0 | x1 | x2) & y & w);
            2'b01:   return (x0 | x1 | x2) & y & w;
            2'b10:   return ~((x0 & x1 & x2) | y | w);
            default: return (x0 & x1 & x2) | y | w;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mode = 2'b11;
        a0 = 4'hF; a1 = 4'hF; a2 = 4'hF; b0 = 4'hF; c0 = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (z !== 4'h0) begin n_err++; $display("FAIL reset_z: got %h want 0", z); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        repeat (4) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL reset_quiet: got out_valid=%b busy=%b want 0/0", out_valid, busy);
            end
        end
    endtask

    task automatic test_truth();
        logic [3:0] want [4];
        want[0] = 4'b1110; want[1] = 4'b0001; want[2] = 4'b0000; want[3] = 4'b1111;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            a0 = 4'b0001; a1 = 4'b0000; a2 = 4'b0000; b0 = 4'b1111; c0 = 4'b0011;
            mode = m[1:0]; in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL truth_in_ready m%0d: got %b want 1", m, in_ready); end
            @(posedge clk); #1;
            // Operands change after acceptance and must not reach the result.
            in_valid = 1'b0; a0 = 4'b1000; b0 = 4'b0000; mode = ~mode;
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL truth_early m%0d: got out_valid=%b want 0", m, out_valid); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL truth_valid m%0d: got %b want 1", m, out_valid); end
            n_cmp++; if (z !== want[m]) begin n_err++; $display("FAIL truth_z m%0d: got %b want %b", m, z, want[m]); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL truth_drain m%0d: got out_valid=%b busy=%b want 0/0", m, out_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want;
        logic       vwant;
        mode = 2'b01; a1 = 4'h0; a2 = 4'h0; b0 = 4'hF; c0 = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 16);
            a0 = c[3:0];
            #1;
            vwant = (c >= 2 && c < 18);
            want  = 4'(c - 2);
            if (c < 16) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
            end
            n_cmp++; if (out_valid !== vwant) begin n_err++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, out_valid, vwant); end
            if (vwant) begin
                n_cmp++; if (z !== want) begin n_err++; $display("FAIL stream_z c%0d: got %h want %h", c, z, want); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        mode = 2'b01; a1 = 4'h0; a2 = 4'h0; b0 = 4'hF; c0 = 4'hF;
        out_ready = 1'b0; in_valid = 1'b1; a0 = 4'd1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept1: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        a0 = 4'd2;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept2: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        a0 = 4'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready i%0d: got %b want 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || z !== 4'd1) begin
                n_err++; $display("FAIL bp_hold i%0d: got out_valid=%b z=%h want 1/1", i, out_valid, z);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (z !== 4'd1) begin n_err++; $display("FAIL bp_release_z: got %h want 1", z); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; a0 = 4'd4;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || z !== 4'd2) begin
            n_err++; $display("FAIL bp_next: got out_valid=%b z=%h want 1/2", out_valid, z);
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_refull: got in_ready=%b want 0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || z !== 4'd3) begin
            n_err++; $display("FAIL bp_third: got out_valid=%b z=%h want 1/3", out_valid, z);
        end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_empty: got out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b01; a1 = 4'h0; a2 = 4'h0; b0 = 4'hF; c0 = 4'hF;
        out_ready = 1'b0; in_valid = 1'b1; a0 = 4'd5;
        @(posedge clk); #1;
        a0 = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1 || z !== 4'd5) begin
            n_err++; $display("FAIL mid_loaded: got busy=%b out_valid=%b z=%h want 1/1/5", busy, out_valid, z);
        end
        reset = 1'b1; in_valid = 1'b1; a0 = 4'd7;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (out_valid !== 1'b0 || z !== 4'd0) begin
            n_err++; $display("FAIL mid_cleared: got out_valid=%b z=%h want 0/0", out_valid, z);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; a0 = 4'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_ghost: got out_valid=%b want 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || z !== 4'd9) begin
            n_err++; $display("FAIL mid_resume: got out_valid=%b z=%h want 1/9", out_valid, z);
        end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_after: got out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_random();
        logic [63:0] q1 [$];
        logic [63:0] q8 [$];
        logic [63:0] want;
        logic [63:0] got_exp;
        int          acc1 = 0, acc8 = 0, out1 = 0, out8 = 0;
        logic        drain;
        for (int c = 0; c < 10040; c++) begin
            drain       = (c >= 10000);
            r_in_valid  = drain ? 1'b0 : ($urandom_range(0, 99) < 70);
            r_out_ready = drain ? 1'b1 : ($urandom_range(0, 99) < 60);
            ra0 = {$urandom, $urandom}; ra1 = {$urandom, $urandom}; ra2 = {$urandom, $urandom};
            rb0 = {$urandom, $urandom}; rc0 = {$urandom, $urandom};
            rmode = 2'($urandom_range(0, 3));
            #1;
            want = ref_fn(rmode, ra0, ra1, ra2, rb0, rc0);
            if (r_in_valid && d1_in_ready) begin q1.push_back(want); acc1++; end
            if (r_in_valid && d8_in_ready) begin q8.push_back(want); acc8++; end
            if (d1_out_valid && r_out_ready) begin
                out1++;
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++; $display("FAIL rand_d1_extra c%0d: got %h want nothing", c, d1_z);
                end else begin
                    got_exp = q1.pop_front();
                    if (d1_z !== got_exp) begin n_err++; $display("FAIL rand_d1_z c%0d: got %h want %h", c, d1_z, got_exp); end
                end
            end
            if (d8_out_valid && r_out_ready) begin
                out8++;
                n_cmp++;
                if (q8.size() == 0) begin
                    n_err++; $display("FAIL rand_d8_extra c%0d: got %h want nothing", c, d8_z);
                end else begin
                    got_exp = q8.pop_front();
                    if (d8_z !== got_exp) begin n_err++; $display("FAIL rand_d8_z c%0d: got %h want %h", c, d8_z, got_exp); end
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (q1.size() != 0 || out1 != acc1) begin
            n_err++; $display("FAIL rand_d1_loss: got %0d outputs want %0d", out1, acc1);
        end
        n_cmp++; if (q8.size() != 0 || out8 != acc8) begin
            n_err++; $display("FAIL rand_d8_loss: got %0d outputs want %0d", out8, acc8);
        end
        n_cmp++; if (d1_busy !== 1'b0 || d8_busy !== 1'b0) begin
            n_err++; $display("FAIL rand_idle: got busy d1=%b d8=%b want 0/0", d1_busy, d8_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
        a0 = '0; a1 = '0; a2 = '0; b0 = '0; c0 = '0;
        r_in_valid = 1'b0; r_out_ready = 1'b1; rmode = 2'b00;
        ra0 = '0; ra1 = '0; ra2 = '0; rb0 = '0; rc0 = '0;
        test_reset();
        test_truth();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
